// File: rtl/raybox_input_conditioner_pkg.sv
// Shared types for the raybox nav-button front end: chord FSM states, the
// button-to-function map and the registered output bundle.
package raybox_input_conditioner_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArm     = 3'd1,
    StMove    = 3'd2,
    StDbg1    = 3'd3,
    StDbg2    = 3'd4,
    StLockout = 3'd5
  } chord_state_e;

  // Button index (K1..K4) driving each move direction
  localparam int unsigned KeyB = 1;
  localparam int unsigned KeyR = 2;
  localparam int unsigned KeyL = 3;
  localparam int unsigned KeyF = 4;

  typedef struct packed {
    logic move_l;
    logic move_r;
    logic move_f;
    logic move_b;
    logic debug_a;
    logic debug_b;
    logic debug_c;
    logic debug_d;
  } nav_out_t;

  // Each output is owned by exactly one state and forced low elsewhere.
  function automatic nav_out_t decode_outputs(chord_state_e st, logic [4:1] p);
    nav_out_t o;
    o = '0;
    case (st)
      StMove: begin
        o.move_l = p[KeyL];
        o.move_r = p[KeyR];
        o.move_f = p[KeyF];
        o.move_b = p[KeyB];
      end
      StDbg1: begin
        o.debug_a = p[KeyF];
        o.debug_b = p[KeyB];
      end
      StDbg2: begin
        o.debug_c = p[KeyR];
        o.debug_d = p[KeyL];
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/raybox_input_conditioner_button_debounce.sv
// One nav button: 2-FF synchroniser, inversion to active-high, then a
// stability counter when RAYBOX_INPUT_DEBOUNCE_EN is defined (plain register otherwise).
module raybox_input_conditioner_button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_n_i,
  output logic pressed_o
);

  logic sync1_q, sync2_q;
  logic p_sync;
  logic pressed_q, pressed_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= raw_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign p_sync = ~sync2_q;

`ifdef RAYBOX_INPUT_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Any agreeing sample restarts the count; the final differing sample flips and clears.
  always_comb begin
    cnt_d     = '0;
    pressed_d = pressed_q;
    if (p_sync != pressed_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        pressed_d = p_sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
  assign pressed_d = p_sync;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pressed_q <= 1'b0;
    end else begin
      pressed_q <= pressed_d;
    end
  end

  assign pressed_o = pressed_q;

endmodule

// File: rtl/raybox_input_conditioner.sv
// Raybox nav-button front end: per-button sync/debounce plus chord-window FSM
// decoding moves and debug chords. Debounce counters exist only with RAYBOX_INPUT_DEBOUNCE_EN.
module raybox_input_conditioner
  import raybox_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CHORD_WINDOW    = 1250000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [4:1] k_n_i,
  output logic       move_l_o,
  output logic       move_r_o,
  output logic       move_f_o,
  output logic       move_b_o,
  output logic       debug_a_o,
  output logic       debug_b_o,
  output logic       debug_c_o,
  output logic       debug_d_o,
  output logic [4:1] pressed_o
);

  localparam int unsigned WinW = (CHORD_WINDOW > 1) ? $clog2(CHORD_WINDOW) : 1;

  logic [4:1] pressed;

  for (genvar i = 1; i <= 4; i++) begin : g_btn
    raybox_input_conditioner_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .raw_n_i  (k_n_i[i]),
      .pressed_o(pressed[i])
    );
  end

  logic any_pressed, chord1, chord2;

  assign any_pressed = |pressed;
  assign chord1      = pressed[2] & pressed[3];
  assign chord2      = pressed[1] & pressed[4];

  chord_state_e    state_q, state_d;
  logic [WinW-1:0] win_q, win_d;
  nav_out_t        out_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      StIdle: begin
        if (any_pressed) begin
          state_d = StArm;
          win_d   = WinW'(CHORD_WINDOW - 1);
        end
      end
      StArm: begin
        if (chord1)              state_d = StDbg1;
        else if (chord2)         state_d = StDbg2;
        else if (!any_pressed)   state_d = StIdle;
        else if (win_q == '0)    state_d = StMove;
        else                     win_d   = win_q - 1'b1;
      end
      StMove: begin
        if (chord1)              state_d = StDbg1;
        else if (chord2)         state_d = StDbg2;
        else if (!any_pressed)   state_d = StIdle;
      end
      StDbg1: begin
        if (!chord1)             state_d = StLockout;
      end
      StDbg2: begin
        // DBG1 outranks DBG2, so forming chord1 here also drops out
        if (!chord2 || chord1)   state_d = StLockout;
      end
      StLockout: begin
        if (!any_pressed)        state_d = StIdle;
      end
      default:                   state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state entry.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      win_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      out_q   <= decode_outputs(state_d, pressed);
    end
  end

  assign move_l_o  = out_q.move_l;
  assign move_r_o  = out_q.move_r;
  assign move_f_o  = out_q.move_f;
  assign move_b_o  = out_q.move_b;
  assign debug_a_o = out_q.debug_a;
  assign debug_b_o = out_q.debug_b;
  assign debug_c_o = out_q.debug_c;
  assign debug_d_o = out_q.debug_d;
  assign pressed_o = pressed;

endmodule

// File: tb/tb_raybox_input_conditioner.sv
// Bench for raybox_input_conditioner with short debounce/window settings; adapts its
// expected press latency to whether RAYBOX_INPUT_DEBOUNCE_EN is defined.
module tb_raybox_input_conditioner;

  localparam int D = 4;
  localparam int W = 8;
`ifdef RAYBOX_INPUT_DEBOUNCE_EN
  localparam bit DebEn = 1'b1;
  localparam int PL    = 2 + D;
`else
  localparam bit DebEn = 1'b0;
  localparam int PL    = 3;
`endif

  localparam int MIdle = 0, MArm = 1, MMove = 2, MDbg1 = 3, MDbg2 = 4, MLock = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:1] k_n;
  logic       move_l, move_r, move_f, move_b;
  logic       debug_a, debug_b, debug_c, debug_d;
  logic [4:1] pressed;
  logic [7:0] obs;

  assign obs = {move_l, move_r, move_f, move_b, debug_a, debug_b, debug_c, debug_d};

  raybox_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CHORD_WINDOW   (W)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .k_n_i    (k_n),
    .move_l_o (move_l),
    .move_r_o (move_r),
    .move_f_o (move_f),
    .move_b_o (move_b),
    .debug_a_o(debug_a),
    .debug_b_o(debug_b),
    .debug_c_o(debug_c),
    .debug_d_o(debug_d),
    .pressed_o(pressed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: raw samples delayed two edges, a sliding window of the last D
  // synced samples for debounce, and a timestamp for the chord window.
  logic [4:1] m_r1, m_r2, m_p;
  logic [4:1] m_hist[$];
  int         m_st, m_arm, m_cyc;
  logic [7:0] m_out;

  task automatic model_reset();
    m_r1 = 4'hF; m_r2 = 4'hF; m_p = '0;
    m_hist.delete();
    m_st = MIdle; m_arm = 0; m_cyc = 0; m_out = '0;
  endtask

  task automatic model_step();
    logic [4:1] ps, np;
    logic any, c1, c2;
    m_cyc++;
    ps = ~m_r2;
    m_r2 = m_r1;
    m_r1 = k_n;
    np = m_p;
    if (DebEn) begin
      m_hist.push_back(ps);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      if (m_hist.size() == D) begin
        for (int b = 1; b <= 4; b++) begin
          bit all_diff;
          all_diff = 1'b1;
          foreach (m_hist[j]) if (m_hist[j][b] == m_p[b]) all_diff = 1'b0;
          if (all_diff) np[b] = ~m_p[b];
        end
      end
    end else begin
      np = ps;
    end
    any = |m_p;
    c1  = m_p[2] & m_p[3];
    c2  = m_p[1] & m_p[4];
    case (m_st)
      MIdle: if (any) begin m_st = MArm; m_arm = m_cyc; end
      MArm: begin
        if (c1) m_st = MDbg1;
        else if (c2) m_st = MDbg2;
        else if (!any) m_st = MIdle;
        else if (m_cyc - m_arm >= W) m_st = MMove;
      end
      MMove: begin
        if (c1) m_st = MDbg1;
        else if (c2) m_st = MDbg2;
        else if (!any) m_st = MIdle;
      end
      MDbg1: if (!c1) m_st = MLock;
      MDbg2: if (!c2 || c1) m_st = MLock;
      default: if (!any) m_st = MIdle;
    endcase
    m_out = '0;
    case (m_st)
      MMove: m_out[7:4] = {m_p[3], m_p[2], m_p[4], m_p[1]};
      MDbg1: m_out[3:2] = {m_p[4], m_p[1]};
      MDbg2: m_out[1:0] = {m_p[2], m_p[3]};
      default: ;
    endcase
    m_p = np;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("cycle", int'({obs, pressed}), int'({m_out, m_p}));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Inputs must already be set; counts edges until pressed[b] and obs[ob] first rise.
  task automatic measure(input string name, input int b, input int ob);
    int p_first, o_first;
    p_first = -1;
    o_first = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (p_first < 0 && pressed[b]) p_first = n;
      if (o_first < 0 && obs[ob]) o_first = n;
    end
    check({name, "_pressed_lat"}, p_first, PL);
    check({name, "_move_lat"}, o_first, PL + 1 + W);
  endtask

  typedef struct {
    logic [4:1] k_n;
    logic [7:0] out;
    logic [4:1] p;
  } vec_t;

  vec_t vecs[19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // outputs: {L, R, F, B, A, B, C, D}
    vecs[0]  = '{4'b1111, 8'b0000_0000, 4'b0000};
    vecs[1]  = '{4'b1011, 8'b1000_0000, 4'b0100};  // K3 -> moveL
    vecs[2]  = '{4'b1001, 8'b0000_0000, 4'b0110};  // +K2 late -> DBG1
    vecs[3]  = '{4'b0001, 8'b0000_1000, 4'b1110};  // +K4 -> debugA
    vecs[4]  = '{4'b0101, 8'b0000_0000, 4'b1010};  // -K3 -> lockout
    vecs[5]  = '{4'b1111, 8'b0000_0000, 4'b0000};
    vecs[6]  = '{4'b0110, 8'b0000_0000, 4'b1001};  // K1+K4 -> DBG2
    vecs[7]  = '{4'b0010, 8'b0000_0001, 4'b1101};  // +K3 -> debugD
    vecs[8]  = '{4'b0000, 8'b0000_0000, 4'b1111};  // +K2 forms c1 -> lockout
    vecs[9]  = '{4'b1111, 8'b0000_0000, 4'b0000};
    vecs[10] = '{4'b0000, 8'b0000_1100, 4'b1111};  // all four -> DBG1 priority
    vecs[11] = '{4'b1111, 8'b0000_0000, 4'b0000};
    vecs[12] = '{4'b0111, 8'b0010_0000, 4'b1000};  // K4 -> moveF
    vecs[13] = '{4'b0110, 8'b0000_0000, 4'b1001};  // +K1 in MOVE -> DBG2
    vecs[14] = '{4'b1110, 8'b0000_0000, 4'b0001};  // -K4 -> lockout holds
    vecs[15] = '{4'b1111, 8'b0000_0000, 4'b0000};
    vecs[16] = '{4'b1110, 8'b0001_0000, 4'b0001};  // K1 -> moveB
    vecs[17] = '{4'b1100, 8'b0101_0000, 4'b0011};  // +K2 in MOVE -> moveR too
    vecs[18] = '{4'b1111, 8'b0000_0000, 4'b0000};

    reset = 1'b1;
    k_n   = 4'hF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'(obs), 0);
    check("reset_pressed", int'(pressed), 0);
    reset = 1'b0;
    ticks(4);

    foreach (vecs[i]) begin
      k_n = vecs[i].k_n;
      ticks(24);
      check($sformatf("vec%0d_out", i), int'(obs), int'(vecs[i].out));
      check($sformatf("vec%0d_pressed", i), int'(pressed), int'(vecs[i].p));
    end

    // K1 press latency from idle
    k_n = 4'b1110;
    measure("k1", 1, 4);
    k_n = 4'hF;
    ticks(24);

    // K4 bounce, then held low
    begin
      bit quiet;
      quiet = 1'b1;
      for (int s = 0; s < 10; s++) begin
        k_n[4] = s[0];
        for (int c = 0; c < 2; c++) begin
          tick();
          if (obs != 8'h00) quiet = 1'b0;
        end
      end
      check("bounce_quiet", int'(quiet), 1);
    end
    k_n[4] = 1'b0;
    measure("k4_bounce", 4, 5);

    // Async reset while moveF is active
    check("pre_reset_move_f", int'(move_f), 1);
    reset = 1'b1;
    k_n   = 4'hF;
    #1;
    check("async_reset_outputs", int'(obs), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    ticks(20);
    check("idle_after_reset_out", int'(obs), 0);
    check("idle_after_reset_pressed", int'(pressed), 0);

    // Random presses against the model
    for (int s = 0; s < 300; s++) begin
      k_n = 4'($urandom);
      ticks(int'($urandom_range(1, 14)));
    end
    k_n = 4'hF;
    ticks(24);
    check("final_idle", int'(obs), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
